// File: rtl/param_fifo_pkg.sv
// Shared definitions for the parametrised single-clock FIFO: default
// geometry, a depth helper that stays sane for degenerate widths, and the
// occupancy type used at the default geometry.
package param_fifo_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 4;
   localparam int DEFAULT_DATA_WIDTH = 8;

   // Occupancy needs one bit more than the address so that DEPTH itself fits.
   typedef logic [DEFAULT_ADDR_WIDTH:0] count_t;

   // Number of RAM entries for a given address width; never returns zero so
   // that elaboration can reach the parameter checks instead of failing on
   // an empty array first.
   function automatic int depth_of(input int addr_width);
      if (addr_width < 1) begin
         return 1;
      end
      return 1 << addr_width;
   endfunction

endpackage

// File: rtl/param_fifo_ram.sv
// Simple dual-port storage for param_fifo: one synchronous write port and
// one asynchronous read port. The asynchronous read lets the controller
// either register the word (standard mode) or expose it directly
// (first-word-fall-through) from the same array.
module param_fifo_ram
   import param_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH = depth_of(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   // Store the incoming word on an accepted write; contents are never cleared.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO controller: pointers, occupancy count,
// status flags, sticky error flags, synchronous flush and the read port.
// Define PARAM_FIFO_FWFT_EN for first-word-fall-through reads; by default
// rd_data is registered one cycle after an accepted read.
module param_fifo
   import param_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
   parameter int ALMOST_FULL_TH  = 14,
   parameter int ALMOST_EMPTY_TH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = depth_of(ADDR_WIDTH);
   localparam int CNT_W = ADDR_WIDTH + 1;

   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_TH     = CNT_W'(ALMOST_FULL_TH);
   localparam logic [ADDR_WIDTH:0] AE_TH     = CNT_W'(ALMOST_EMPTY_TH);
   localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

   // Reject illegal configurations while elaborating.
   if (ADDR_WIDTH < 1) begin : g_chk_addr
      $error("param_fifo: ADDR_WIDTH must be at least 1");
   end
   if ((ALMOST_FULL_TH < 1) || (ALMOST_FULL_TH > DEPTH)) begin : g_chk_af
      $error("param_fifo: ALMOST_FULL_TH must lie in 1..DEPTH");
   end
   if ((ALMOST_EMPTY_TH < 0) || (ALMOST_EMPTY_TH > DEPTH - 1)) begin : g_chk_ae
      $error("param_fifo: ALMOST_EMPTY_TH must lie in 0..DEPTH-1");
   end

   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic [ADDR_WIDTH:0]   count_next;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  ram_we;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // Flags come only from the registered count, so they never depend
   // combinationally on this cycle's requests.
   assign full         = (count == DEPTH_CNT);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_TH);
   assign almost_empty = (count <= AE_TH);

   // Acceptance looks at the pre-edge state only: a read never frees a slot
   // for a same-cycle write, and a write never feeds a same-cycle read.
   assign wr_acc     = wr_en & ~full;
   assign rd_acc     = rd_en & ~empty;
   assign count_next = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);

   // A flushed or reset cycle must not disturb storage.
   assign ram_we = wr_acc & ~flush & ~reset;

   param_fifo_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_ptr[ADDR_WIDTH-1:0]),
      .wdata (wr_data),
      .raddr (rd_ptr[ADDR_WIDTH-1:0]),
      .rdata (ram_rdata)
   );

   // Pointers, occupancy and sticky error flags; flush outranks requests.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         count <= count_next;
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         if (rd_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end

`ifdef PARAM_FIFO_FWFT_EN
   // The head word is visible whenever the FIFO holds data.
   assign rd_data  = empty ? '0 : ram_rdata;
   assign rd_valid = ~empty;
`else
   // Capture the head word on an accepted read and strobe rd_valid for one
   // cycle; rd_data otherwise holds, including across a flush.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else if (flush) begin
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_acc;
         if (rd_acc) begin
            rd_data <= ram_rdata;
         end
      end
   end
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo in its default (registered read) build.
// A queue-based reference model tracks contents and sticky flags; a short
// vector table, hand-written corner sequences and a random run are all
// compared against it.
module tb_param_fifo;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AF_TH = 14;
   localparam int AE_TH = 2;

   logic          clk;
   logic          reset;
   logic          flush;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state
   logic [DW-1:0] m_q[$];
   logic [DW-1:0] m_rd_data;
   logic          m_rd_valid;
   logic          m_ovf;
   logic          m_udf;

   typedef struct {
      logic          flush;
      logic          wr;
      logic [DW-1:0] wd;
      logic          rd;
      logic [AW:0]   exp_count;
      logic          exp_valid;
      logic [DW-1:0] exp_data;
      logic          exp_udf;
      logic          exp_ovf;
   } vec_t;

   vec_t vecs[9];

   param_fifo #(
      .ADDR_WIDTH      (AW),
      .DATA_WIDTH      (DW),
      .ALMOST_FULL_TH  (AF_TH),
      .ALMOST_EMPTY_TH (AE_TH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_q.delete();
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
      m_udf      = 1'b0;
   endtask

   // One clock edge of the FIFO as seen from outside: decisions use the
   // occupancy before the edge; the read pops first, then the write appends.
   task automatic modelEdge(input logic f, input logic wr, input logic [DW-1:0] wd, input logic rd);
      int pre;
      pre = m_q.size();
      if (f) begin
         m_q.delete();
         m_rd_valid = 1'b0;
         m_ovf      = 1'b0;
         m_udf      = 1'b0;
      end else begin
         m_rd_valid = 1'b0;
         if (rd) begin
            if (pre > 0) begin
               m_rd_data  = m_q.pop_front();
               m_rd_valid = 1'b1;
            end else begin
               m_udf = 1'b1;
            end
         end
         if (wr) begin
            if (pre < DEPTH) m_q.push_back(wd);
            else m_ovf = 1'b1;
         end
      end
   endtask

   task automatic checkOutput();
      int n;
      n = m_q.size();
      checkField("count",        32'(count),        32'(n));
      checkField("full",         32'(full),         32'(n == DEPTH));
      checkField("empty",        32'(empty),        32'(n == 0));
      checkField("almost_full",  32'(almost_full),  32'(n >= AF_TH));
      checkField("almost_empty", 32'(almost_empty), 32'(n <= AE_TH));
      checkField("overflow",     32'(overflow),     32'(m_ovf));
      checkField("underflow",    32'(underflow),    32'(m_udf));
      checkField("rd_valid",     32'(rd_valid),     32'(m_rd_valid));
      checkField("rd_data",      32'(rd_data),      32'(m_rd_data));
   endtask

   // Drive one cycle of requests, let the edge happen, then compare.
   task automatic applyStimulus(input logic f, input logic wr, input logic [DW-1:0] wd, input logic rd);
      flush   = f;
      wr_en   = wr;
      wr_data = wd;
      rd_en   = rd;
      @(posedge clk);
      modelEdge(f, wr, wd, rd);
      #1;
      checkOutput();
   endtask

   // Assert reset between edges and check outputs before any clock arrives.
   task automatic doReset();
      reset = 1'b1;
      #2;
      modelReset();
      checkOutput();
      @(posedge clk);
      #1;
      flush = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      reset = 1'b0;
      #1;
      checkOutput();
   endtask

   initial begin
      logic seen_aa;
      logic [DW-1:0] wd;

      reset   = 1'b0;
      flush   = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      rd_en   = 1'b0;
      modelReset();

      //                 flush wr  data   rd   count valid data   udf  ovf
      vecs[0] = '{1'b0, 1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 8'h3C, 1'b0, 5'd2, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 8'h77, 1'b1, 5'd1, 1'b1, 8'h3C, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 8'h3C, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 8'h77, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h77, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 1'b1, 8'h11, 1'b1, 5'd0, 1'b0, 8'h77, 1'b0, 1'b0};
      vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h77, 1'b0, 1'b0};

      #2;
      doReset();

      // Vector table
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].flush, vecs[i].wr, vecs[i].wd, vecs[i].rd);
         checkField("vec_count",     32'(count),     32'(vecs[i].exp_count));
         checkField("vec_rd_valid",  32'(rd_valid),  32'(vecs[i].exp_valid));
         checkField("vec_rd_data",   32'(rd_data),   32'(vecs[i].exp_data));
         checkField("vec_underflow", 32'(underflow), 32'(vecs[i].exp_udf));
         checkField("vec_overflow",  32'(overflow),  32'(vecs[i].exp_ovf));
      end

      // Fill 0x00..0x0F then drain in order
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, 1'b1, DW'(i), 1'b0);
         checkField("fill_almost_full", 32'(almost_full), 32'(i + 1 >= AF_TH));
         checkField("fill_full",        32'(full),        32'(i + 1 == DEPTH));
      end
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
         checkField("drain_data",  32'(rd_data),  32'(i));
         checkField("drain_valid", 32'(rd_valid), 32'd1);
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      checkField("drain_empty", 32'(empty), 32'd1);

      // Overflow: 17th write is dropped
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, DW'(8'h40 + i), 1'b0);
      applyStimulus(1'b0, 1'b1, 8'hAA, 1'b0);
      checkField("ovf_flag",  32'(overflow), 32'd1);
      checkField("ovf_count", 32'(count),    32'd16);
      seen_aa = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
         if (rd_data == 8'hAA) seen_aa = 1'b1;
      end
      checkField("ovf_no_AA", 32'(seen_aa), 32'd0);

      // Underflow on an empty FIFO, then flush clears it
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkField("udf_flag",  32'(underflow), 32'd1);
      checkField("udf_valid", 32'(rd_valid),  32'd0);
      checkField("udf_data",  32'(rd_data),   32'h4F);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      checkField("flush_udf", 32'(underflow), 32'd0);
      checkField("flush_ovf", 32'(overflow),  32'd0);

      // Steady streaming at count 5 across several pointer wraps
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, DW'(i), 1'b0);
      for (int i = 5; i < 45; i++) begin
         applyStimulus(1'b0, 1'b1, DW'(i), 1'b1);
         checkField("stream_count", 32'(count),   32'd5);
         checkField("stream_data",  32'(rd_data), 32'(i - 5));
      end
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

      // Both requests at count 0 and at count 16
      applyStimulus(1'b0, 1'b1, 8'h5A, 1'b1);
      checkField("both_empty_count", 32'(count),     32'd1);
      checkField("both_empty_udf",   32'(underflow), 32'd1);
      checkField("both_empty_valid", 32'(rd_valid),  32'd0);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, DW'(8'h80 + i), 1'b0);
      applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1);
      checkField("both_full_count", 32'(count),    32'd15);
      checkField("both_full_ovf",   32'(overflow), 32'd1);
      checkField("both_full_data",  32'(rd_data),  32'h80);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

      // Asynchronous reset in the middle of a burst at count 9
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, DW'(8'h20 + i), 1'b0);
      checkField("pre_reset_count", 32'(count), 32'd9);
      doReset();
      checkField("post_reset_count", 32'(count),   32'd0);
      checkField("post_reset_data",  32'(rd_data), 32'd0);
      applyStimulus(1'b0, 1'b1, 8'hC3, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkField("post_reset_word", 32'(rd_data), 32'hC3);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         wd = DW'($urandom_range(0, 255));
         applyStimulus($urandom_range(0, 99) < 3,
                       $urandom_range(0, 99) < 55,
                       wd,
                       $urandom_range(0, 99) < 50);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
- Next-generation synchronous single-clock FIFO, parametrised in width, depth and flag thresholds.
- Adds simultaneous read+write, an occupancy count, almost-full/almost-empty flags, sticky overflow/underflow error flags, a synchronous flush and a read-valid strobe.
- Sits between producer and consumer datapaths inside one clock domain, replacing the earlier fixed-behaviour FIFO.

Parameters:
- ADDR_WIDTH, 4: address bits; DEPTH = 2**ADDR_WIDTH entries.
- DATA_WIDTH, 8: word width in bits.
- ALMOST_FULL_TH, 14: almost_full asserts when count >= this value; legal range 1..DEPTH.
- ALMOST_EMPTY_TH, 2: almost_empty asserts when count <= this value; legal range 0..DEPTH-1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of contents.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  write word.
- rd_en  input  1  read request.
- rd_data  output  DATA_WIDTH  read word.
- rd_valid  output  1  rd_data updated this cycle.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= ALMOST_FULL_TH.
- almost_empty  output  1  count <= ALMOST_EMPTY_TH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk.
  - While reset is high: pointers = 0, count = 0, rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Resulting flags: empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - RAM contents are not cleared.
  - Reset mid-operation aborts everything; in-flight words are lost.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits; the MSB is the wrap bit and the low bits index the RAM; they wrap naturally modulo 2*DEPTH.
- Status flags: full, empty, almost_full and almost_empty decode combinationally from the registered count. No flag has a combinational path from wr_en or rd_en.
- Accept rules:
  - wr_acc = wr_en & ~full.
  - rd_acc = rd_en & ~empty.
  - Evaluated on the pre-edge state only. A read does not free a slot for a same-cycle write when full; a write does not feed a same-cycle read when empty.
- Simultaneous accepted read and write: both pointers advance and count is unchanged.
- Count update: count_next = count + wr_acc - rd_acc.
- Read latency (standard mode): on rd_acc, rd_data <= RAM[rd_ptr] at the same edge, and rd_valid = 1 for exactly that cycle. Otherwise rd_data holds its value and rd_valid = 0.
- Rejected write (wr_en & full): data discarded, no state change except overflow <= 1.
- Rejected read (rd_en & empty): rd_data unchanged, rd_valid = 0, underflow <= 1.
- Sticky error flags: overflow and underflow clear only on reset or flush.
- Flush: has priority over rd_en and wr_en in the same cycle. Pointers and count go to 0; rd_valid, overflow and underflow go to 0; rd_data holds.
- Parameter checks: elaboration-time assertions on threshold ranges and ADDR_WIDTH >= 1.

Optional Feature:
- Macro: PARAM_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - rd_data = RAM[rd_ptr] combinationally whenever ~empty; 0 when empty.
  - rd_valid = ~empty, so the head word is visible before it is popped.
  - rd_en pops the head (rd_acc as above); the next word appears the following cycle.
- Undefined: standard registered 1-cycle read behaviour as described above.

Decomposition:
- Package param_fifo_pkg:
  - Default width/depth constants.
  - Function clog2-safe depth helper.
  - typedef for the count type.
- Sub-module param_fifo_ram: simple dual-port RAM.
  - Ports: clk; write port (we, waddr, wdata); read port (raddr, rdata).
  - Asynchronous read, so one RAM serves both modes; the registered rd_data lives in the controller.
- Controller holds pointers, count, flags and the output register.

Test Plan:
- Reset, then 16 writes of 0x00..0x0F, then 16 reads -> full = 1 after write 16; almost_full = 1 after write 14; rd_data sequence 0x00..0x0F, each with rd_valid one cycle after its rd_en; empty = 1 at end.
- Fill with 16 words, then a 17th write of 0xAA -> write ignored, overflow = 1, count stays 16; the 16 reads return no 0xAA.
- Empty FIFO, rd_en pulse -> underflow = 1, rd_valid = 0, rd_data unchanged; then flush -> underflow = 0.
- Count = 5, wr_en and rd_en high together for 40 cycles with an incrementing pattern -> count stays 5 throughout, pointers wrap at least twice, output order preserved.
- Count = 0 with wr_en and rd_en both high -> write accepted, read rejected, underflow = 1, count = 1. Count = 16 with both high -> read accepted, write rejected, overflow = 1, count = 15.
- Reset asserted asynchronously mid-burst at count = 9 -> all outputs take reset values immediately without waiting for a clock edge; a subsequent write then read returns the new word.
